core_fetch_ctrl: RTL

Fetch controller that sequences instruction-packet requests toward the master processor's instruction port. It generates packet-aligned fetch addresses, limits in-flight requests with a credit scheme, and buffers returned 4-instruction packets in a small FIFO for decode. It also handles PC redirects by flushing buffered packets and discarding stale in-flight responses. It sits between the PC/redirect source (branch unit) and the decode stage.

---
 rtl/core_pkg.sv | 40 ++++
 rtl/core_fetch_fifo.sv | 82 ++++++++
 rtl/core_fetch_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types and helpers for the core front end.
package core_pkg;

  localparam int CORE_INSTR_PACKET_NUM = 4;
  localparam int CORE_PKT_BYTES        = 16;

  typedef logic [31:0]                         core_pc_t;
  typedef logic [31:0]                         core_fetch_addr_t;
  typedef logic [CORE_INSTR_PACKET_NUM*32-1:0] core_instr_packet_t;
  typedef logic [CORE_INSTR_PACKET_NUM-1:0]    core_slot_mask_t;

  // One buffered packet on its way to decode.
  typedef struct packed {
    core_instr_packet_t data;
    core_fetch_addr_t   pc;
    core_slot_mask_t    mask;
  } core_fetch_pkt_t;

  // Bookkeeping carried alongside each outstanding request.
  typedef struct packed {
    core_fetch_addr_t addr;
    core_slot_mask_t  mask;
  } core_fetch_tag_t;

  typedef enum logic {
    FETCH_ST_BOOT  = 1'b0,
    FETCH_ST_FETCH = 1'b1
  } core_fetch_state_e;

  // Packet-aligned address containing the given PC.
  function automatic core_fetch_addr_t core_pkt_align(input core_pc_t pc);
    return {pc[31:4], 4'b0000};
  endfunction

  // Slots at or after the PC's position within its packet are valid.
  function automatic core_slot_mask_t core_first_mask(input core_pc_t pc);
    return core_slot_mask_t'(4'b1111 << pc[3:2]);
  endfunction

endpackage

// File: rtl/core_fetch_fifo.sv
// Small synchronous FIFO with flush; output reads as zero while empty.
module core_fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign count_o    = count_q;
  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);

  // Pointer, count and storage updates; flush discards everything held.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = ptr_next(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_next(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Control state, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; unread entries are masked by the empty check.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  overflow_a: assert property (@(posedge clk) disable iff (rst)
    !(push_i && !flush_i && full_o && !pop_i));

endmodule

// File: rtl/core_fetch_ctrl.sv
// Fetch controller: issues packet requests under a credit limit, buffers
// returned packets for decode, and squashes stale work on redirect.
module core_fetch_ctrl
  import core_pkg::*;
#(
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         redirect_valid_i,
  input  logic [31:0]  redirect_pc_i,
  output logic         req_valid_o,
  input  logic         req_ready_i,
  output logic [31:0]  req_addr_o,
  input  logic         rsp_valid_i,
  input  logic [127:0] rsp_packet_i,
  output logic         pkt_valid_o,
  input  logic         pkt_ready_i,
  output logic [127:0] pkt_data_o,
  output logic [31:0]  pkt_pc_o,
  output logic [3:0]   pkt_mask_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  core_fetch_state_e state_q, state_d;
  core_pc_t          fetch_pc_q, fetch_pc_d;
  core_slot_mask_t   first_mask_q, first_mask_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic              req_fire;
  logic [CNT_W:0]    credit_used;
  logic              pkt_push;
  logic              pkt_pop;
  logic              pkt_empty;
  logic              pkt_full;
  logic [CNT_W-1:0]  pkt_count;
  core_fetch_pkt_t   pkt_in;
  core_fetch_pkt_t   pkt_out;
  core_fetch_tag_t   tag_in;
  core_fetch_tag_t   tag_out;
  logic              tag_empty;
  logic              tag_full;
  logic [CNT_W-1:0]  tag_count;

  assign credit_used = {1'b0, out_cnt_q} + {1'b0, pkt_count};
  assign req_valid_o = (state_q == FETCH_ST_FETCH) &&
                       (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
  assign req_addr_o  = core_pkt_align(fetch_pc_q);
  assign req_fire    = req_valid_o && req_ready_i;

  assign tag_in   = '{addr: req_addr_o, mask: first_mask_q};
  assign pkt_in   = '{data: rsp_packet_i, pc: tag_out.addr, mask: tag_out.mask};
  assign pkt_push = rsp_valid_i && (drop_cnt_q == '0) && !redirect_valid_i;
  assign pkt_pop  = pkt_valid_o && pkt_ready_i;

  assign pkt_valid_o = !pkt_empty;
  assign pkt_data_o  = pkt_out.data;
  assign pkt_pc_o    = pkt_out.pc;
  assign pkt_mask_o  = pkt_out.mask;

  core_fetch_fifo #(.WIDTH($bits(core_fetch_tag_t)), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (1'b0),
    .push_i      (req_fire),
    .push_data_i (tag_in),
    .pop_i       (rsp_valid_i),
    .pop_data_o  (tag_out),
    .empty_o     (tag_empty),
    .full_o      (tag_full),
    .count_o     (tag_count)
  );

  core_fetch_fifo #(.WIDTH($bits(core_fetch_pkt_t)), .DEPTH(FIFO_DEPTH)) u_pkt_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect_valid_i),
    .push_i      (pkt_push),
    .push_data_i (pkt_in),
    .pop_i       (pkt_pop),
    .pop_data_o  (pkt_out),
    .empty_o     (pkt_empty),
    .full_o      (pkt_full),
    .count_o     (pkt_count)
  );

  // Next-state: PC advance, credit counters and redirect squash.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    first_mask_d = first_mask_q;
    out_cnt_d    = out_cnt_q + CNT_W'(req_fire) - CNT_W'(rsp_valid_i);
    drop_cnt_d   = drop_cnt_q;

    case (state_q)
      FETCH_ST_BOOT:  state_d = FETCH_ST_FETCH;
      FETCH_ST_FETCH: state_d = FETCH_ST_FETCH;
      default:        state_d = FETCH_ST_BOOT;
    endcase

    if (req_fire) begin
      fetch_pc_d   = req_addr_o + 32'd16;
      first_mask_d = '1;
    end
    if (rsp_valid_i && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - 1'b1;
    end

    // Everything still outstanding after this cycle belongs to the old path.
    if (redirect_valid_i) begin
      fetch_pc_d   = redirect_pc_i;
      first_mask_d = core_first_mask(redirect_pc_i);
      drop_cnt_d   = out_cnt_d;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH_ST_BOOT;
      fetch_pc_q   <= RESET_PC;
      first_mask_q <= core_first_mask(RESET_PC);
      out_cnt_q    <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      first_mask_q <= first_mask_d;
      out_cnt_q    <= out_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  rsp_legal_a: assert property (@(posedge clk) disable iff (rst)
    !rsp_valid_i || (out_cnt_q != '0));

  tag_sync_a: assert property (@(posedge clk) disable iff (rst)
    (tag_count == out_cnt_q) && !(req_fire && tag_full) && (!rsp_valid_i || !tag_empty));

  pkt_room_a: assert property (@(posedge clk) disable iff (rst)
    !(pkt_push && pkt_full && !pkt_pop));

endmodule
